// File: rtl/stage_pipe_reg.sv
// stage_pipe_reg: DEPTH-deep valid/ready pipeline register carrying instruction + PC.
// Define STAGE_PIPE_PERF_EN to build the saturating stall/bubble performance counters.
module stage_pipe_reg #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         instr_in,
  input  logic [PC_W-1:0]            counter_in,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         instr_out,
  output logic [PC_W-1:0]            counter_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                stall_cnt,
  output logic [15:0]                bubble_cnt
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]   v_q, v_d, adv;
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [INSTR_W-1:0] instr_d [DEPTH];
  logic [PC_W-1:0]    pc_q    [DEPTH];
  logic [PC_W-1:0]    pc_d    [DEPTH];
  logic [CNT_W-1:0]   count_d;
  logic               accept;

  // Advance chain runs from the output stage back towards stage 0.
  always_comb begin
    logic a;
    a = !stall && (!v_q[DEPTH-1] || out_ready);
    adv[DEPTH-1] = a;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      a      = !stall && (!v_q[k] || a);
      adv[k] = a;
    end
  end

  assign in_ready = adv[0] && !flush && !reset;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    v_d     = v_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      v_d     = '0;
      instr_d = '{default: '0};
      pc_d    = '{default: '0};
    end else begin
      if (adv[0]) begin
        v_d[0]     = accept;
        instr_d[0] = accept ? instr_in   : '0;
        pc_d[0]    = accept ? counter_in : '0;
      end
      // Invalid stages always hold zero data, so shifting an empty stage forward zeroes the next one.
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k]) begin
          v_d[k]     = v_q[k-1];
          instr_d[k] = instr_q[k-1];
          pc_d[k]    = pc_q[k-1];
        end
      end
    end
    count_d = '0;
    for (int k = 0; k < DEPTH; k++) count_d = count_d + CNT_W'(v_d[k]);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    if (reset) begin
      v_q   <= '0;
      count <= '0;
      // NOTE: the data arrays are reset too, because outputs must read zero whenever a stage is empty.
      for (int k = 0; k < DEPTH; k++) begin
        instr_q[k] <= '0;
        pc_q[k]    <= '0;
      end
    end else begin
      v_q     <= v_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      count   <= count_d;
    end
  end

  assign out_valid   = v_q[DEPTH-1];
  assign instr_out   = v_q[DEPTH-1] ? instr_q[DEPTH-1] : '0;
  assign counter_out = v_q[DEPTH-1] ? pc_q[DEPTH-1]    : '0;

`ifdef STAGE_PIPE_PERF_EN
  // Saturating counters; flush deliberately leaves them alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (!out_valid && out_ready && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: doc/stage_pipe_reg.md
STAGE_PIPE_REG -- requirements
Module: stage_pipe_reg

Interface
REQ-001 Parameter INSTR_W, 32, instruction field width in bits.
REQ-002 Parameter PC_W, 32, program-counter field width in bits.
REQ-003 Parameter DEPTH, 1, number of register stages; legal range 1..8.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-006 IN_VALID  input  1  upstream holds a valid instruction.
REQ-007 IN_READY  output  1  stage 0 accepts this cycle (combinational).
REQ-008 INSTR_IN  input  INSTR_W  instruction from fetch.
REQ-009 COUNTER_IN  input  PC_W  PC of INSTR_IN.
REQ-010 STALL  input  1  hazard-unit hold; freezes all stages.
REQ-011 FLUSH  input  1  branch/jump squash; invalidates all stages.
REQ-012 OUT_VALID  output  1  last stage holds valid data.
REQ-013 OUT_READY  input  1  downstream accepts this cycle.
REQ-014 INSTR_OUT  output  INSTR_W  instruction of last stage; zero (NOP) when OUT_VALID=0.
REQ-015 COUNTER_OUT  output  PC_W  PC of last stage; zero when OUT_VALID=0.
REQ-016 COUNT  output  clog2(DEPTH+1)  number of valid stages.
REQ-017 STALL_CNT  output  16  stall-cycle counter (see Configuration).
REQ-018 BUBBLE_CNT  output  16  output-bubble counter (see Configuration).

Function
REQ-019 Each stage k SHALL hold valid bit V[k], instruction and PC; stage DEPTH-1 drives the outputs.
REQ-020 Stage k SHALL be "advancing" when !STALL and (V[k]=0 or stage k+1 advancing); stage DEPTH-1 advances when !STALL and (V=0 or OUT_READY).
REQ-021 IN_READY SHALL equal stage-0 advancing and !FLUSH.
REQ-022 An advancing stage SHALL load stage k-1 contents (stage 0: IN_VALID, INSTR_IN, COUNTER_IN, V loaded as IN_VALID and IN_READY).
REQ-023 A stage whose contents leave without replacement SHALL clear V and zero its data fields.
REQ-024 Latency SHALL be DEPTH cycles from accepted input to OUT_VALID with OUT_READY=1 and no STALL; throughput one per cycle.
REQ-025 Full pipe (COUNT=DEPTH) with OUT_READY=1 SHALL accept and emit in the same cycle without bubble.
REQ-026 STALL=1 SHALL hold all stage contents unchanged, force IN_READY=0, and no downstream transfer is counted that cycle.
REQ-027 FLUSH=1 SHALL clear all V and zero all data at the next edge, overriding STALL and input; the IN_VALID item offered that cycle is dropped.
REQ-028 COUNT SHALL equal the sum of V[k], registered consistently with stage state.
REQ-029 Invalid data SHALL never appear on outputs: INSTR_OUT/COUNTER_OUT = 0 whenever OUT_VALID=0.

Reset
REQ-030 RESET=1 SHALL at the next edge clear all V, zero all data, COUNT=0, STALL_CNT=0, BUBBLE_CNT=0; RESET overrides FLUSH and STALL.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight items; IN_READY SHALL be 0 while RESET=1.

Configuration
REQ-032 Macro STAGE_PIPE_PERF_EN defined: STALL_CNT increments each non-reset cycle with STALL=1; BUBBLE_CNT increments each non-reset cycle with OUT_VALID=0 and OUT_READY=1; both saturate at 16'hFFFF; FLUSH does not clear them.
REQ-033 Macro undefined: counters not built, STALL_CNT and BUBBLE_CNT tied to 0; all other behaviour identical.

Verification
REQ-034 DEPTH=3, RESET then stream INSTR 0x1..0x5, PC 0x0,0x4,...; OUT_READY=1 -> 0x1 appears on cycle 3 after first accept, one per cycle, COUNT reaches 3.
REQ-035 Full pipe, OUT_READY=0 for 4 cycles -> IN_READY=0, outputs hold 0x1/0x0, COUNT=3, no loss or duplication after release.
REQ-036 STALL=1 for 2 cycles mid-stream -> all outputs frozen, IN_READY=0, STALL_CNT=2 with STAGE_PIPE_PERF_EN, 0 without.
REQ-037 FLUSH and STALL asserted together with COUNT=3 -> next cycle COUNT=0, OUT_VALID=0, INSTR_OUT=0, offered input dropped.
REQ-038 RESET asserted with COUNT=2 and IN_VALID=1 -> next cycle all outputs 0, counters 0; 70000 bubble cycles with PERF_EN -> BUBBLE_CNT=0xFFFF.
